store_aligner: RTL
==================

STORE_ALIGNER -- requirements
Module: store_aligner

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid  input  1  core presents a store.
REQ-004 SHALL have port req_ready  output  1  block can accept a store.
REQ-005 SHALL have port addr  input  32  byte address of store.
REQ-006 SHALL have port wdata  input  32  register data, LSB-aligned (byte in [7:0], half in [15:0]).
REQ-007 SHALL have port size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port done  output  1  one-cycle pulse, store completed.
REQ-009 SHALL have port err  output  1  one-cycle pulse, store rejected, no memory write.
REQ-010 SHALL have port mem_req  output  1  data-memory write request.
REQ-011 SHALL have port mem_addr  output  32  word-aligned address, [1:0]=00.
REQ-012 SHALL have port mem_wdata  output  32  lane-positioned write data.
REQ-013 SHALL have port mem_be  output  4  byte enables, bit i = lane i = bits [8i+7:8i].
REQ-014 SHALL have port mem_ack  input  1  memory accepted current request.

Function
REQ-015 SHALL implement FSM states IDLE, BEAT1, BEAT2, RESP; req_ready=1 only in IDLE.
REQ-016 SHALL capture addr, wdata, size when req_valid && req_ready; inputs ignored otherwise.
REQ-017 SHALL, on acceptance of size=11, go to RESP with err flagged; no mem_req ever asserted.
REQ-018 SHALL, on acceptance of a legal store, enter BEAT1; mem_req rises the cycle after acceptance.
REQ-019 SHALL hold mem_req, mem_addr, mem_wdata, mem_be stable until mem_ack sampled high; mem_ack ignored outside BEAT1/BEAT2.
REQ-020 SHALL drive mem_wdata = captured wdata rotated left by 8*addr[1:0] bits, in both beats (little-endian lanes).
REQ-021 SHALL set BEAT1 mem_addr = {addr[31:2],2'b00}; mem_be = lanes addr[1:0] .. addr[1:0]+nbytes-1 clipped at lane 3 (nbytes 1/2/4).
REQ-022 SHALL, if the store crosses a word boundary (split enabled, see REQ-029), enter BEAT2 after BEAT1 ack; mem_addr = BEAT1 address + 4 modulo 2^32 (0xFFFFFFFC wraps to 0); mem_be = remaining low lanes.
REQ-023 SHALL deassert mem_req for at least one cycle between BEAT1 ack and BEAT2 request.
REQ-024 SHALL enter RESP on final ack; RESP lasts one cycle with done=1 (or err=1 per REQ-017), then IDLE.
REQ-025 SHALL never assert done and err together; both are 0 outside RESP.
REQ-026 SHALL support single-beat misaligned half at addr[1:0]=01 (mem_be=0110) without error.

Reset
REQ-027 SHALL, on rst_n low, immediately force IDLE, req_ready=1, done=0, err=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, regardless of state.
REQ-028 SHALL abandon any in-flight beat on reset mid-operation; no done/err reported for it.

Configuration
REQ-029 SHALL use macro STORE_SPLIT_EN: defined -> boundary-crossing half (addr[1:0]=11) and misaligned word stores execute as BEAT1+BEAT2.
REQ-030 SHALL, without STORE_SPLIT_EN, treat half at addr[1:0]=11 and word with addr[1:0]!=00 like size=11: err pulse, no bus activity; BEAT2 unreachable.

Verification
REQ-031 SHALL check byte store addr=0x103, wdata=0x000000AB, ack next cycle -> one beat mem_addr=0x100, mem_be=1000, mem_wdata[31:24]=0xAB, done pulse.
REQ-032 SHALL check word store addr=0x200, wdata=0x11223344, ack delayed 3 cycles -> mem outputs stable 4 cycles, mem_be=1111, done once.
REQ-033 SHALL check (STORE_SPLIT_EN) word addr=0x1FE, wdata=0xAABBCCDD -> beat1 0x1FC be=1100 wdata=0xCCDDAABB; beat2 0x200 be=0011 same data; done.
REQ-034 SHALL check size=11 and (without macro) word addr=0x1FE -> err pulse one cycle, mem_req never high, req_ready high after.
REQ-035 SHALL check rst_n low while BEAT1 waiting on ack -> mem_req 0 immediately, no done/err; next store completes normally.

Source files
------------

// File: rtl/store_aligner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : store_aligner                                                     |
// | Purpose : Places byte/half/word stores on little-endian lanes of a 32-bit   |
// |           memory port. Optional macro STORE_SPLIT_EN splits stores that     |
// |           cross a word boundary into two beats.                             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module store_aligner (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_err;
    logic        r_split;
    logic [3:0]  r_be2;

    logic [3:0]  w_mask;
    logic [7:0]  w_be_full;
    logic [31:0] w_rot;
    logic        w_cross;
    logic        w_illegal;
    logic        w_split;
    logic        w_accept;
    logic        w_ack;

    always_comb begin
        w_mask = 4'b0000;
        case (size)
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            2'b10:   w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    // Lanes beyond lane 3 (bits [7:4]) are the ones a second beat must cover.
    assign w_be_full = {4'b0000, w_mask} << addr[1:0];
    assign w_cross   = |w_be_full[7:4];

    always_comb begin
        w_rot = wdata;
        case (addr[1:0])
            2'd0: w_rot = wdata;
            2'd1: w_rot = {wdata[23:0], wdata[31:24]};
            2'd2: w_rot = {wdata[15:0], wdata[31:16]};
            2'd3: w_rot = {wdata[7:0],  wdata[31:8]};
            default: w_rot = wdata;
        endcase
    end

`ifdef STORE_SPLIT_EN
    assign w_illegal = (size == 2'b11);
    assign w_split   = w_cross;
`else
    assign w_illegal = (size == 2'b11) || w_cross;
    assign w_split   = 1'b0;
`endif

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_ack     = mem_req && mem_ack;

    assign req_ready = (r_state == IDLE);
    assign done      = (r_state == RESP) && !r_err;
    assign err       = (r_state == RESP) &&  r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_illegal ? RESP : BEAT1;
            BEAT1:   if (w_ack)    w_next = r_split ? BEAT2 : RESP;
            BEAT2:   if (w_ack)    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus outputs are registered so they hold steady until the ack is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_split   <= 1'b0;
            r_be2     <= 4'b0000;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_err   <= w_illegal;
                        r_split <= w_split;
                        r_be2   <= w_be_full[7:4];
                        if (!w_illegal) begin
                            mem_req   <= 1'b1;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= w_rot;
                            mem_be    <= w_be_full[3:0];
                        end
                    end
                end
                BEAT1: begin
                    if (w_ack) begin
                        mem_req <= 1'b0;
                        if (r_split) begin
                            mem_addr <= mem_addr + 32'd4;
                            mem_be   <= r_be2;
                        end else begin
                            mem_addr  <= 32'd0;
                            mem_wdata <= 32'd0;
                            mem_be    <= 4'b0000;
                        end
                    end
                end
                BEAT2: begin
                    // First BEAT2 cycle is the mandatory idle gap on the bus.
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        mem_be    <= 4'b0000;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
